// File: rtl/mem_arbiter.sv
// Purpose: arbitrates an instruction port and a data port onto one SRAM-like memory port,
//          tracks outstanding requests in order and routes each response to its owner.
// Latency: request path and response path are both combinational (zero cycles).
//          Backpressure: m_addr_ok is passed back to the granted port only. m_req is held low
//          while OT_DEPTH requests are outstanding. A port that stalls keeps the grant locked.
// Ports:   clk/reset (sync, active-high); inst_* read-only requester; data_* read/write requester;
//          m_* memory side; err_o sticky protocol error (abandoned lock or unsolicited data_ok).
module mem_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction side
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    // data side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    // memory side
    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic [31:0] m_rdata,
    input  logic        m_data_ok,
    // status
    output logic        err_o
);

    localparam int PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CW = $clog2(OT_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OT_DEPTH);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // grant lock: holds the owner of a request the memory has not yet accepted
    logic   lock_vld;
    owner_t lock_owner;

    // outstanding-owner FIFO
    owner_t          owner_q [OT_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic   gnt_vld;
    owner_t gnt;
    logic   gnt_req;
    logic   ot_full;
    logic   accept;
    logic   pop;
    owner_t head;

    // Grant depends only on registered lock state and the requests, never on m_addr_ok,
    // so the memory-side handshake cannot loop back into m_req or the request fields.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = OWN_INST;
        if (lock_vld) begin
            gnt_vld = 1'b1;
            gnt     = lock_owner;
        end else if (data_req) begin
            gnt_vld = 1'b1;
            gnt     = OWN_DATA;
        end else if (inst_req) begin
            gnt_vld = 1'b1;
            gnt     = OWN_INST;
        end
    end

    assign gnt_req = (gnt == OWN_DATA) ? data_req : inst_req;
    assign ot_full = (count == FULL_CNT);
    assign m_req   = gnt_vld && gnt_req && !ot_full;

    always_comb begin
        m_wr    = 1'b0;
        m_size  = 3'd2;
        m_wstrb = 4'b0000;
        m_addr  = inst_addr;
        m_wdata = 32'd0;
        if (gnt == OWN_DATA) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end
    end

    assign accept       = m_req && m_addr_ok;
    assign inst_addr_ok = accept && (gnt == OWN_INST);
    assign data_addr_ok = accept && (gnt == OWN_DATA);

    // A request accepted this cycle is not yet in the FIFO, so it cannot be popped now.
    assign pop          = m_data_ok && (count != '0);
    assign head         = owner_q[rd_ptr];
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign inst_data_ok = pop && (head == OWN_INST);
    assign data_data_ok = pop && (head == OWN_DATA);

    // Owner storage needs no reset: entries are only read below the valid count.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[wr_ptr] <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock_vld   <= 1'b0;
            lock_owner <= OWN_INST;
            err_o      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A locked owner dropping its request breaks the protocol; release the grant.
            if (lock_vld && !gnt_req) begin
                lock_vld <= 1'b0;
                err_o    <= 1'b1;
            end else if (m_req && !m_addr_ok) begin
                lock_vld   <= 1'b1;
                lock_owner <= gnt;
            end else if (accept) begin
                lock_vld <= 1'b0;
            end

            if (m_data_ok && (count == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter OT_DEPTH, default 4 (power of two, >=2): maximum outstanding accepted requests awaiting data_ok.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have inst-side ports: inst_req in 1; inst_addr in 32; inst_addr_ok out 1; inst_rdata out 32; inst_data_ok out 1 (read-only, size fixed 2, wr 0).
REQ-005 The block SHALL have data-side ports: data_req in 1; data_wr in 1; data_size in 3; data_wstrb in 4; data_addr in 32; data_wdata in 32; data_addr_ok out 1; data_rdata out 32; data_data_ok out 1.
REQ-006 The block SHALL have memory-side ports: m_req out 1; m_wr out 1; m_size out 3; m_wstrb out 4; m_addr out 32; m_wdata out 32; m_addr_ok in 1; m_rdata in 32; m_data_ok in 1.
REQ-007 The block SHALL have err_o, output, 1: sticky protocol-error flag.

Function
REQ-008 Handshake on every port SHALL be SRAM-like: request accepted in a cycle with req && addr_ok; responses return in acceptance order, one per data_ok pulse.
REQ-009 Grant SHALL be a 1-bit selection (INST/DATA) computed combinationally each cycle: if lock valid, grant = locked owner; else data_req wins over inst_req; none if neither requests.
REQ-010 m_req SHALL equal granted port's req AND NOT ot_full; m_wr/m_size/m_wstrb/m_addr/m_wdata SHALL be the granted port's fields (INST: wr 0, size 3'd2, wstrb 4'b0000, wdata 0).
REQ-011 Granted port's addr_ok SHALL equal m_addr_ok && m_req; non-granted port's addr_ok SHALL be 0.
REQ-012 Lock: when m_req=1 and m_addr_ok=0, lock SHALL be set next cycle to current owner; lock SHALL clear in the cycle after acceptance; while locked, m_* fields SHALL come from the locked owner (requester holds fields stable per protocol).
REQ-013 If the locked owner deasserts req, lock SHALL clear the next cycle and err_o SHALL set.
REQ-014 Outstanding tracker SHALL be an OT_DEPTH-entry FIFO of owner IDs plus count 0..OT_DEPTH; push owner on acceptance, pop on m_data_ok.
REQ-015 ot_full = (count == OT_DEPTH); while full, m_req SHALL be 0 and no addr_ok SHALL assert; a data_ok in the same cycle does not unblock until the next cycle.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo OT_DEPTH.
REQ-017 On m_data_ok with count>0, m_rdata SHALL be routed to inst_rdata and data_rdata unconditionally; only the FIFO-head owner's data_ok SHALL assert, same cycle (zero latency).
REQ-018 m_data_ok with count==0 (pop and push coincident on empty excluded: a same-cycle accept is not poppable) SHALL be dropped, no data_ok asserted, err_o set.
REQ-019 err_o SHALL remain 1 until reset.
REQ-020 No combinational path SHALL exist from m_addr_ok to m_req or m_* fields.

Reset
REQ-021 While reset=1 at a rising edge: count 0, pointers 0, lock cleared, err_o 0.
REQ-022 During and after reset with no requests: m_req 0, all addr_ok/data_ok 0; in-flight responses from before reset SHALL be treated as unsolicited (REQ-018).

Verification
REQ-023 Both req same cycle, m_addr_ok=1 -> data port accepted (data_addr_ok=1, inst_addr_ok=0); inst accepted next cycle; two data_ok pulses -> data_data_ok then inst_data_ok.
REQ-024 inst_req=1, m_addr_ok=0 for 3 cycles, data_req rises cycle 2 -> m_addr stays inst_addr until accepted; data granted the cycle after.
REQ-025 OT_DEPTH=4, 4 inst accepts with no data_ok -> count 4, m_req 0 with inst_req=1; one m_data_ok -> inst_data_ok=1, m_req=1 next cycle.
REQ-026 Accept and m_data_ok same cycle at count 2 -> count stays 2; IDs returned in order across pointer wrap (>=6 transactions alternating owners).
REQ-027 m_data_ok with count 0 -> no port data_ok, err_o=1 persists until reset; reset asserted mid-lock with count 3 -> next cycle count 0, lock cleared, err_o 0.
